// File: rtl/mul_tile_scheduler.sv
// Iterative unsigned multiplier controller: walks every digit pair of two WIDTH-bit
// operands through one shared external 3x3 tile and accumulates the shifted partial products.
module mul_tile_scheduler #(
  parameter int WIDTH = 12  // must be a multiple of 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy,
  output logic [2:0]           tile_a,
  output logic [2:0]           tile_b,
  output logic                 tile_en,
  input  logic [5:0]           tile_c
);

  localparam int DIGITS = WIDTH / 3;
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = 2 * WIDTH;
  localparam int SHW    = $clog2(6 * DIGITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and payloads are held stable while valid waits for ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IDXW-1:0]   i_q, i_d;
  logic [IDXW-1:0]   j_q, j_d;
  logic [2:0]        hold_a_q, hold_a_d;
  logic [2:0]        hold_b_q, hold_b_d;

  logic [2:0]        a_dig [DIGITS];
  logic [2:0]        b_dig [DIGITS];
  logic [2:0]        da, db;
  logic              gate;
  logic [SHW-1:0]    shamt;
  logic [PW-1:0]     pp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digits
    assign a_dig[g] = a_q[3*g +: 3];
    assign b_dig[g] = b_q[3*g +: 3];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;

    da    = a_dig[i_q];
    db    = b_dig[j_q];
    gate  = (state_q == S_RUN) && (da != 3'd0) && (db != 3'd0);
    shamt = SHW'(3 * (int'(i_q) + int'(j_q)));
    pp    = PW'(tile_c) << shamt;

    // Gated pairs leave the tile inputs parked on their last values so the tile sees no toggles.
    tile_en  = gate;
    tile_a   = gate ? da : hold_a_q;
    tile_b   = gate ? db : hold_b_q;
    hold_a_d = tile_a;
    hold_b_d = tile_b;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          state_d = ((in_a == '0) || (in_b == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (gate) begin
          acc_d = acc_q + pp;
        end
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        // First DONE cycle registers out_valid; the handshake then returns to IDLE.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_product = acc_q;

endmodule

// File: doc/mul_tile_scheduler.md
Name: mul_tile_scheduler

Overview:
- Iterative unsigned multiplier controller that shares one external 3x3 partial-product tile across all digit pairs of two WIDTH-bit operands.
- Drives the tile's 3-bit A/B inputs, captures its 6-bit product, and accumulates it shifted by 3*(i+j).
- Sits between the mantissa-path front end (valid/ready) and a single gate-level tile instance, trading area for cycles.
- Low-power features: zero-digit tile gating and a zero-operand bypass.

Parameters:
- WIDTH, 12, operand width in bits; must be a multiple of 3. DIGITS = WIDTH/3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  scheduler can accept operands.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_product  output  2*WIDTH  unsigned product.
- busy  output  1  high in RUN or DONE.
- tile_a  output  3  digit of A to tile.
- tile_b  output  3  digit of B to tile.
- tile_en  output  1  tile result is used this cycle.
- tile_c  input  6  combinational tile product of tile_a*tile_b.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_product=0; tile_a=0; tile_b=0; tile_en=0.
  - Indices i,j=0; accumulator=0.
  - Reset mid-RUN or mid-DONE discards the operation; no product is emitted.
- Digit k of X is X[3k+2:3k], k=0..DIGITS-1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a,b; acc=0; i=j=0.
  - If in_a==0 or in_b==0: go to DONE directly (acc=0, no RUN cycles). Otherwise go to RUN.
- RUN: in_ready=0. Exactly DIGITS*DIGITS cycles, order j fastest (i=0,j=0..D-1; i=1,...).
  - da=digit i of a_reg, db=digit j of b_reg.
  - If da!=0 and db!=0:
    - tile_en=1; tile_a=da; tile_b=db.
    - On the clock edge: acc += tile_c << 3*(i+j).
  - Otherwise:
    - tile_en=0; tile_a/tile_b hold their previous values (no toggling).
    - acc unchanged.
  - tile_a/tile_b/tile_en are combinational from registered state and indices. tile_c is sampled in the same cycle.
  - Index advance: j++. When j==DIGITS-1: j=0, i++.
  - When i==j==DIGITS-1 the final accumulate occurs and state goes to DONE.
- DONE:
  - out_valid=1; out_product=acc, held stable; in_ready=0.
  - On out_ready: out_valid drops at the next edge; state=IDLE.
  - in_valid is ignored throughout DONE.
- Latency, accept edge = edge 0:
  - Nonzero operands: out_valid high after edge DIGITS^2+1.
  - Zero operand: out_valid high after edge 1.
  - Cycle count does not depend on digit gating.
- Throughput: one operation at a time. The next accept is possible at the earliest one cycle after the out handshake.
- Width rules:
  - acc is 2*WIDTH bits and cannot overflow, since the max product (2^WIDTH-1)^2 fits.
  - Shift amount is at most 6*(DIGITS-1).
- out_product keeps its last value in IDLE; only out_valid qualifies it.
- busy = (state != IDLE).

Test Plan:
- Max operands, WIDTH=12:
  - a=0xFFF, b=0xFFF, accepted at edge 0 -> tile_en high all 16 RUN cycles.
  - out_valid after edge 17; out_product=0xFFE001.
- Zero bypass: a=0x000, b=0x07B -> no RUN cycles, tile_en never high, out_valid after edge 1, out_product=0.
- Digit gating: a=0x007, b=0x005 -> 16 RUN cycles with tile_en high exactly 1 cycle (i=0,j=0); out_product=0x000023.
- Backpressure:
  - a=0x123, b=0x456 with out_ready=0 for 5 cycles in DONE -> out_product=0x04EDC2 held stable; out_valid=1; in_ready=0.
  - in_valid pulses are ignored.
  - Release out_ready -> IDLE, in_ready=1 next cycle.
- Reset mid-run: assert rst at RUN cycle 7 -> all outputs 0 immediately and in_ready=1 after release; no out_valid pulse. A following op a=0x002, b=0x003 yields 0x000006.
- Back-to-back ops with out_ready tied high:
  - Three random operand pairs -> each product equals the reference multiply.
  - Each accept occurs exactly 1 cycle after the prior out handshake.
